// File: rtl/sb_tx_pkg.sv
// ============================================================================
// Module  : sb_tx_pkg
// Brief   : Shared state, grant encodings and gap counter width for SB TX.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sb_tx_pkg;

   localparam int GAP_CNT_W = 4;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_SEND_PAT  = 3'd1;
   localparam logic [2:0] S_SEND_HDR  = 3'd2;
   localparam logic [2:0] S_SEND_DATA = 3'd3;
   localparam logic [2:0] S_GAP       = 3'd4;

   localparam logic [1:0] GNT_NONE = 2'd0;
   localparam logic [1:0] GNT_PAT  = 2'd1;
   localparam logic [1:0] GNT_LTSM = 2'd2;
   localparam logic [1:0] GNT_RDI  = 2'd3;

   // Maps the one-hot round-robin grant (bit0 LTSM, bit1 RDI) to the owner code.
   function automatic logic [1:0] msg_grant(input logic [1:0] rr_gnt);
      return rr_gnt[1] ? GNT_RDI : GNT_LTSM;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sb_rr_arb2.sv
// ============================================================================
// Module  : sb_rr_arb2
// Brief   : Two-requester round-robin arbiter; pointer moves only on advance.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sb_rr_arb2 (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [1:0] i_req,
   input  logic       i_advance,
   output logic [1:0] o_gnt
);

   // 0 favours requester 0, 1 favours requester 1
   logic r_ptr;

   always_comb begin
      o_gnt = 2'b00;
      if (r_ptr == 1'b0) begin
         if (i_req[0])      o_gnt = 2'b01;
         else if (i_req[1]) o_gnt = 2'b10;
      end else begin
         if (i_req[1])      o_gnt = 2'b10;
         else if (i_req[0]) o_gnt = 2'b01;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ptr <= 1'b0;
      end else if (i_advance && (o_gnt != 2'b00)) begin
         r_ptr <= o_gnt[0];
      end
   end

endmodule

`default_nettype wire

// File: rtl/sb_tx_arbiter.sv
// ============================================================================
// Module  : sb_tx_arbiter
// Brief   : Shares the SB TX serializer between pattern, LTSM and RDI sources.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sb_tx_arbiter
   import sb_tx_pkg::*;
#(
   parameter int DW         = 64,
   parameter int GAP_CYCLES = 4
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic [DW-1:0] i_pat_data,
   input  logic          i_pat_valid,
   output logic          o_pat_ready,
   input  logic [DW-1:0] i_ltsm_hdr,
   input  logic [DW-1:0] i_ltsm_data,
   input  logic          i_ltsm_has_data,
   input  logic          i_ltsm_valid,
   output logic          o_ltsm_ack,
   input  logic [DW-1:0] i_rdi_hdr,
   input  logic [DW-1:0] i_rdi_data,
   input  logic          i_rdi_has_data,
   input  logic          i_rdi_valid,
   output logic          o_rdi_ack,
   output logic [DW-1:0] o_ser_data,
   output logic          o_ser_valid,
   input  logic          i_ser_ready,
   output logic          o_busy,
   output logic [1:0]    o_grant
);

   localparam logic [GAP_CNT_W-1:0] c_gap_load =
      (GAP_CYCLES > 0) ? GAP_CNT_W'(GAP_CYCLES - 1) : '0;

   logic [2:0]           r_state;
   logic [DW-1:0]        r_ser_data;
   logic                 r_ser_valid;
   logic [1:0]           r_grant;
   logic [DW-1:0]        r_data;
   logic                 r_has_data;
   logic [GAP_CNT_W-1:0] r_gap_cnt;
   logic                 r_pat_ready;
   logic                 r_ltsm_ack;
   logic                 r_rdi_ack;

   logic [1:0]           w_rr_gnt;
   logic                 w_rr_adv;
   logic                 w_xfer;
   logic                 w_msg_last;

   assign w_xfer     = r_ser_valid & i_ser_ready;
   assign w_msg_last = w_xfer & (((r_state == S_SEND_HDR) & ~r_has_data) |
                                 (r_state == S_SEND_DATA));
   // Pattern words pre-empt message arbitration, so the pointer only moves on a message grant.
   assign w_rr_adv   = (r_state == S_IDLE) & ~i_pat_valid;

   sb_rr_arb2 u_rr (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_req     ({i_rdi_valid, i_ltsm_valid}),
      .i_advance (w_rr_adv),
      .o_gnt     (w_rr_gnt)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_ser_data  <= '0;
         r_ser_valid <= 1'b0;
         r_grant     <= GNT_NONE;
         r_data      <= '0;
         r_has_data  <= 1'b0;
         r_gap_cnt   <= '0;
         r_pat_ready <= 1'b0;
         r_ltsm_ack  <= 1'b0;
         r_rdi_ack   <= 1'b0;
      end else begin
         r_pat_ready <= 1'b0;
         r_ltsm_ack  <= 1'b0;
         r_rdi_ack   <= 1'b0;
         if (w_msg_last) begin
            r_ltsm_ack  <= (r_grant == GNT_LTSM);
            r_rdi_ack   <= (r_grant == GNT_RDI);
            r_ser_valid <= 1'b0;
            if (GAP_CYCLES == 0) begin
               r_state <= S_IDLE;
               r_grant <= GNT_NONE;
            end else begin
               r_state   <= S_GAP;
               r_gap_cnt <= c_gap_load;
            end
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (i_pat_valid) begin
                     r_ser_data  <= i_pat_data;
                     r_ser_valid <= 1'b1;
                     r_grant     <= GNT_PAT;
                     r_state     <= S_SEND_PAT;
                  end else if (w_rr_gnt != 2'b00) begin
                     r_ser_data  <= w_rr_gnt[1] ? i_rdi_hdr      : i_ltsm_hdr;
                     r_data      <= w_rr_gnt[1] ? i_rdi_data     : i_ltsm_data;
                     r_has_data  <= w_rr_gnt[1] ? i_rdi_has_data : i_ltsm_has_data;
                     r_ser_valid <= 1'b1;
                     r_grant     <= msg_grant(w_rr_gnt);
                     r_state     <= S_SEND_HDR;
                  end
               end
               S_SEND_PAT: begin
                  if (w_xfer) begin
                     r_pat_ready <= 1'b1;
                     r_ser_valid <= 1'b0;
                     r_grant     <= GNT_NONE;
                     r_state     <= S_IDLE;
                  end
               end
               S_SEND_HDR: begin
                  if (w_xfer) begin
                     r_ser_data <= r_data;
                     r_state    <= S_SEND_DATA;
                  end
               end
               S_SEND_DATA: begin
               end
               S_GAP: begin
                  if (r_gap_cnt == '0) begin
                     r_state <= S_IDLE;
                     r_grant <= GNT_NONE;
                  end else begin
                     r_gap_cnt <= r_gap_cnt - 1'b1;
                  end
               end
               default: begin
                  r_state     <= S_IDLE;
                  r_ser_valid <= 1'b0;
                  r_grant     <= GNT_NONE;
               end
            endcase
         end
      end
   end

   assign o_ser_data  = r_ser_data;
   assign o_ser_valid = r_ser_valid;
   assign o_grant     = r_grant;
   assign o_pat_ready = r_pat_ready;
   assign o_ltsm_ack  = r_ltsm_ack;
   assign o_rdi_ack   = r_rdi_ack;
   assign o_busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire
